branch_pred_queue: RTL and testbench

- Tracks every in-flight conditional branch that fetch predicted with the branch history table.
- Fetch pushes one entry per predicted branch. Execute resolves the oldest entry in order.
- On resolution the block issues a one-cycle BHT update (counter index + actual outcome) that drives the table's write_addr/was_taken inputs.
- On a misprediction it raises a redirect to fetch and squashes all younger entries.

---
 rtl/branch_pred_queue.sv | 129 ++++++++++++
 tb/tb_branch_pred_queue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_pred_queue.sv
// In-order queue of BHT-predicted branches; resolves the oldest, issues BHT update and redirect.
// Latency: update/mispredict pulses appear 1 cycle after the resolving edge.
// Backpressure: push_ready drops when full or during the single RECOVER cycle after a squash/flush.
module branch_pred_queue #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 5,
    parameter int PC_W  = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_valid,
    input  logic [IDX_W-1:0]             push_idx,
    input  logic                         push_pred,
    input  logic [PC_W-1:0]              push_pc,
    output logic                         push_ready,
    input  logic                         resolve_valid,
    input  logic                         resolve_taken,
    input  logic [PC_W-1:0]              resolve_target,
    input  logic                         flush,
    output logic                         upd_valid,
    output logic [IDX_W-1:0]             upd_addr,
    output logic                         upd_taken,
    output logic                         mispredict,
    output logic [PC_W-1:0]              redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         underflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             pred;
        logic [PC_W-1:0]  pc;
    } entry_t;

    typedef enum logic {NORMAL, RECOVER} state_t;

    state_t             state, state_nxt;
    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    entry_t             head;
    logic               do_pop, do_push, mis, empty_resolve;

    always_comb begin
        push_ready    = 1'b0;
        do_pop        = 1'b0;
        mis           = 1'b0;
        do_push       = 1'b0;
        empty_resolve = 1'b0;
        state_nxt     = NORMAL;
        head          = mem[rd_ptr];

        if (state == NORMAL)
            push_ready = (count != CNT_W'(DEPTH));

        if (!flush) begin
            do_pop        = resolve_valid && (count != '0);
            empty_resolve = resolve_valid && (count == '0);
            mis           = do_pop && (head.pred != resolve_taken);
            // A mispredict squashes everything younger, including a same-cycle push
            do_push       = push_valid && push_ready && !mis;
        end

        if (flush || mis)
            state_nxt = RECOVER;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= NORMAL;
        else
            state <= state_nxt;
    end

    // Storage carries no reset; validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= '{idx: push_idx, pred: push_pred, pc: push_pc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= rd_ptr;
            count  <= '0;
        end else if (mis) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            wr_ptr <= rd_ptr + PTR_W'(1);
            count  <= '0;
        end else begin
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_push && !do_pop)
                count <= count + CNT_W'(1);
            else if (do_pop && !do_push)
                count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_valid     <= 1'b0;
            upd_addr      <= '0;
            upd_taken     <= 1'b0;
            mispredict    <= 1'b0;
            redirect_pc   <= '0;
            underflow_err <= 1'b0;
        end else begin
            upd_valid  <= do_pop;
            mispredict <= mis;
            if (do_pop) begin
                upd_addr  <= head.idx;
                upd_taken <= resolve_taken;
            end
            if (mis)
                redirect_pc <= resolve_taken ? resolve_target : head.pc + PC_W'(4);
            if (empty_resolve)
                underflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_pred_queue.sv
// Directed bench: stimulus queues hand-computed BHT-update/redirect expectations; a negedge monitor checks pulses.
module tb_branch_pred_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push_valid;
    logic [4:0]  push_idx;
    logic        push_pred;
    logic [31:0] push_pc;
    logic        push_ready;
    logic        resolve_valid;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic        flush;
    logic        upd_valid;
    logic [4:0]  upd_addr;
    logic        upd_taken;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [2:0]  count;
    logic        underflow_err;

    branch_pred_queue #(.DEPTH(4), .IDX_W(5), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .push_valid(push_valid), .push_idx(push_idx), .push_pred(push_pred), .push_pc(push_pc),
        .push_ready(push_ready),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .resolve_target(resolve_target),
        .flush(flush),
        .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_taken(upd_taken),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .count(count), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic        taken;
        logic        mis;
        logic [31:0] redir;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic expect_upd(input logic [4:0] addr, input logic taken, input logic mis, input logic [31:0] redir);
        exp_t e;
        e.addr = addr; e.taken = taken; e.mis = mis; e.redir = redir;
        sb.push_back(e);
    endtask

    // Apply one cycle of inputs; returns #1 after the sampling edge with inputs idle
    task automatic drive(input logic pv, input logic [4:0] pidx, input logic ppred, input logic [31:0] ppc,
                         input logic rv, input logic rt, input logic [31:0] rtgt, input logic fl);
        push_valid = pv; push_idx = pidx; push_pred = ppred; push_pc = ppc;
        resolve_valid = rv; resolve_taken = rt; resolve_target = rtgt; flush = fl;
        @(posedge clk); #1;
        push_valid = 1'b0; resolve_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic push(input logic [4:0] idx, input logic pred, input logic [31:0] pc);
        drive(1'b1, idx, pred, pc, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic resolve(input logic taken, input logic [31:0] tgt);
        drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, taken, tgt, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // Monitor: every pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && (upd_valid || mispredict)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {62'd0, upd_valid, mispredict}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("upd_valid", 64'(upd_valid), 64'd1);
                check("upd_addr", 64'(upd_addr), 64'(e.addr));
                check("upd_taken", 64'(upd_taken), 64'(e.taken));
                check("mispredict", 64'(mispredict), 64'(e.mis));
                if (e.mis)
                    check("redirect_pc", 64'(redirect_pc), 64'(e.redir));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        push_valid = 1'b0; push_idx = '0; push_pred = 1'b0; push_pc = '0;
        resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_target = '0; flush = 1'b0;
        #12;
        check("rst_count", 64'(count), 64'd0);
        check("rst_upd_valid", 64'(upd_valid), 64'd0);
        check("rst_redirect", 64'(redirect_pc), 64'd0);
        check("rst_underflow", 64'(underflow_err), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: asynchronous reset with entries in flight
        push(5'd1, 1'b0, 32'h10);
        push(5'd2, 1'b0, 32'h20);
        push(5'd3, 1'b0, 32'h30);
        check("t1_count3", 64'(count), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_count", 64'(count), 64'd0);
        check("t1_async_mis", 64'(mispredict), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("t1_ready", 64'(push_ready), 64'd1);

        // 2: correct taken prediction
        push(5'd7, 1'b1, 32'h100);
        expect_upd(5'd7, 1'b1, 1'b0, 32'h0);
        resolve(1'b1, 32'h200);
        check("t2_count", 64'(count), 64'd0);

        // 3: predicted taken, actually not taken; younger entry and a RECOVER-cycle push are dropped
        push(5'd3, 1'b1, 32'h40);
        push(5'd4, 1'b0, 32'h80);
        expect_upd(5'd3, 1'b0, 1'b1, 32'h44);
        resolve(1'b0, 32'h999);
        check("t3_count", 64'(count), 64'd0);
        check("t3_ready_recover", 64'(push_ready), 64'd0);
        push(5'd9, 1'b0, 32'h90);
        check("t3_recover_push_ignored", 64'(count), 64'd0);
        check("t3_ready_back", 64'(push_ready), 64'd1);

        // 4: fill, drain across the wrap, refuse push when full even with a pop
        push(5'd10, 1'b1, 32'h1000);
        push(5'd11, 1'b1, 32'h1004);
        push(5'd12, 1'b1, 32'h1008);
        push(5'd13, 1'b1, 32'h100c);
        check("t4_full_count", 64'(count), 64'd4);
        check("t4_full_ready", 64'(push_ready), 64'd0);
        expect_upd(5'd10, 1'b1, 1'b0, 32'h0);
        resolve(1'b1, 32'h2000);
        expect_upd(5'd11, 1'b1, 1'b0, 32'h0);
        resolve(1'b1, 32'h2000);
        push(5'd14, 1'b1, 32'h1010);
        push(5'd15, 1'b1, 32'h1014);
        check("t4_refill", 64'(count), 64'd4);
        expect_upd(5'd12, 1'b1, 1'b0, 32'h0);
        drive(1'b1, 5'd20, 1'b1, 32'h1018, 1'b1, 1'b1, 32'h2000, 1'b0);
        check("t4_full_push_refused", 64'(count), 64'd3);
        expect_upd(5'd13, 1'b1, 1'b0, 32'h0);
        resolve(1'b1, 32'h2000);
        expect_upd(5'd14, 1'b1, 1'b0, 32'h0);
        resolve(1'b1, 32'h2000);
        expect_upd(5'd15, 1'b1, 1'b0, 32'h0);
        resolve(1'b1, 32'h2000);
        check("t4_drained", 64'(count), 64'd0);

        // 5a: push + correct resolve at count 2
        push(5'd1, 1'b0, 32'h10);
        push(5'd2, 1'b0, 32'h20);
        expect_upd(5'd1, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 5'd5, 1'b1, 32'h500, 1'b1, 1'b0, 32'h0, 1'b0);
        check("t5_count_same", 64'(count), 64'd2);
        expect_upd(5'd2, 1'b0, 1'b0, 32'h0);
        resolve(1'b0, 32'h0);
        expect_upd(5'd5, 1'b1, 1'b0, 32'h0);
        resolve(1'b1, 32'h600);
        check("t5_empty", 64'(count), 64'd0);

        // 5b: push + mispredicting resolve at count 2, taken target used
        push(5'd1, 1'b0, 32'h10);
        push(5'd2, 1'b0, 32'h20);
        expect_upd(5'd1, 1'b1, 1'b1, 32'h300);
        drive(1'b1, 5'd5, 1'b1, 32'h500, 1'b1, 1'b1, 32'h300, 1'b0);
        check("t5_mis_count", 64'(count), 64'd0);
        idle();

        // 6a: fall-through PC wraps at the top of the address space
        push(5'd9, 1'b1, 32'hFFFF_FFFC);
        expect_upd(5'd9, 1'b0, 1'b1, 32'h0);
        resolve(1'b0, 32'h1234);
        idle();
        check("t6_redirect_hold", 64'(redirect_pc), 64'd0);

        // 6b: resolve while empty
        check("t6_underflow_pre", 64'(underflow_err), 64'd0);
        resolve(1'b1, 32'h0);
        check("t6_underflow_set", 64'(underflow_err), 64'd1);
        idle();
        check("t6_underflow_sticky", 64'(underflow_err), 64'd1);

        // 6c: flush beats a same-cycle resolve
        push(5'd6, 1'b1, 32'h60);
        push(5'd7, 1'b1, 32'h70);
        drive(1'b1, 5'd8, 1'b1, 32'h80, 1'b1, 1'b0, 32'h0, 1'b1);
        check("t6_flush_count", 64'(count), 64'd0);
        check("t6_flush_recover", 64'(push_ready), 64'd0);
        idle();
        check("t6_flush_ready", 64'(push_ready), 64'd1);
        check("t6_flush_keeps_underflow", 64'(underflow_err), 64'd1);

        #2 rst_n = 1'b0;
        #1;
        check("t6_underflow_cleared", 64'(underflow_err), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 20 && sb.size() != 0; i++)
            @(posedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
